// File: rtl/merger_pkg.sv
`default_nettype none
// ============================================================================
// Module   : merger_pkg
// Purpose  : Shared width defaults and lane slicing helper for the merge stage.
// Revision : 1.0 - initial release
// ============================================================================
package merger_pkg;

  localparam int DEFAULT_RADIX      = 4;
  localparam int DEFAULT_COORD_BITS = 32;
  localparam int DEFAULT_VALUE_BITS = 32;
  localparam int DEFAULT_DUP_BITS   = 16;

  // Base bit position of lane 'lane' inside a flat lane-packed bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/merger_min_select.sv
`default_nettype none
// ============================================================================
// Module   : merger_min_select
// Purpose  : Combinational minimum finder over the active lane heads. A
//            log2(R)-deep comparator tree yields the minimum coordinate and the
//            lowest lane index holding it; the equal-mask and the modular sum of
//            the matching values are derived from that minimum.
// Revision : 1.0 - initial release
// ============================================================================
module merger_min_select
  import merger_pkg::*;
#(
  parameter  int R        = DEFAULT_RADIX,
  parameter  int C        = DEFAULT_COORD_BITS,
  parameter  int V        = DEFAULT_VALUE_BITS,
  localparam int IDX_BITS = $clog2(R)
) (
  input  logic [R-1:0]        active,
  input  logic [R*C-1:0]      coords,
  input  logic [R*V-1:0]      values,
  output logic                min_valid,
  output logic [C-1:0]        min_coord,
  output logic [IDX_BITS-1:0] min_index,
  output logic [R-1:0]        equal_mask,
  output logic [V-1:0]        equal_sum
);

  localparam int LEVELS = $clog2(R);
  localparam int P      = 1 << LEVELS;

  // Level 0 holds the (padded) leaves; each higher level halves the node count.
  // Ties go to the left child so the lowest lane index wins.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_level
    localparam int N = P >> l;
    logic [N-1:0]               vld;
    logic [N-1:0][C-1:0]        crd;
    logic [N-1:0][IDX_BITS-1:0] idx;

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_node
        if (i < R) begin : g_real
          assign vld[i] = active[i];
          assign crd[i] = coords[lane_lsb(i, C) +: C];
          assign idx[i] = IDX_BITS'(i);
        end else begin : g_pad
          assign vld[i] = 1'b0;
          assign crd[i] = '0;
          assign idx[i] = '0;
        end
      end
    end else begin : g_inner
      for (genvar i = 0; i < N; i++) begin : g_node
        logic pick_left;
        assign pick_left = g_level[l-1].vld[2*i] &&
                           (!g_level[l-1].vld[2*i+1] ||
                            (g_level[l-1].crd[2*i] <= g_level[l-1].crd[2*i+1]));
        assign vld[i] = g_level[l-1].vld[2*i] | g_level[l-1].vld[2*i+1];
        assign crd[i] = pick_left ? g_level[l-1].crd[2*i] : g_level[l-1].crd[2*i+1];
        assign idx[i] = pick_left ? g_level[l-1].idx[2*i] : g_level[l-1].idx[2*i+1];
      end
    end
  end

  assign min_valid = g_level[LEVELS].vld[0];
  assign min_coord = g_level[LEVELS].crd[0];
  assign min_index = g_level[LEVELS].idx[0];

  // Mark every active lane sitting on the minimum and sum their values mod 2^V.
  always_comb begin
    equal_mask = '0;
    equal_sum  = '0;
    for (int i = 0; i < R; i++) begin
      if (active[i] && (coords[lane_lsb(i, C) +: C] == min_coord)) begin
        equal_mask[i] = 1'b1;
        equal_sum     = equal_sum + values[lane_lsb(i, V) +: V];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/radix_stream_merger.sv
`default_nettype none
// ============================================================================
// Module   : radix_stream_merger
// Purpose  : Radix-R merger of coordinate-sorted fibers into one ascending
//            fiber, with optional summing of equal coordinates. One head
//            register per lane, registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module radix_stream_merger
  import merger_pkg::*;
#(
  parameter  int MERGER_RADIX      = DEFAULT_RADIX,
  parameter  int MERGER_COORD_BITS = DEFAULT_COORD_BITS,
  parameter  int MERGER_VALUE_BITS = DEFAULT_VALUE_BITS,
  parameter  int COMBINE_EQUAL     = 1,
  parameter  int DUP_COUNT_BITS    = DEFAULT_DUP_BITS,
  localparam int R                 = MERGER_RADIX,
  localparam int C                 = MERGER_COORD_BITS,
  localparam int V                 = MERGER_VALUE_BITS,
  localparam int IDX_BITS          = $clog2(MERGER_RADIX)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [R-1:0]              in_valid,
  output logic [R-1:0]              in_ready,
  input  logic [R*C-1:0]            in_coord,
  input  logic [R*V-1:0]            in_value,
  input  logic [R-1:0]              in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [C-1:0]              out_coord,
  output logic [V-1:0]              out_value,
  output logic                      out_last,
  output logic [DUP_COUNT_BITS-1:0] dup_count
);

  logic [R-1:0]        head_valid;
  logic [R*C-1:0]      head_coord;
  logic [R*V-1:0]      head_value;
  logic [R-1:0]        head_last;
  logic [R-1:0]        done;

  logic [R-1:0]        active;
  logic                min_valid;
  logic [C-1:0]        min_coord;
  logic [IDX_BITS-1:0] min_index;
  logic [R-1:0]        equal_mask;
  logic [V-1:0]        equal_sum;

  logic                fire;
  logic                final_fire;
  logic [R-1:0]        lowest_onehot;
  logic [R-1:0]        consume;
  logic [V-1:0]        fire_value;
  logic                multi_hit;

  assign active = head_valid & ~done;

  merger_min_select #(
    .R (R),
    .C (C),
    .V (V)
  ) u_min_select (
    .active     (active),
    .coords     (head_coord),
    .values     (head_value),
    .min_valid  (min_valid),
    .min_coord  (min_coord),
    .min_index  (min_index),
    .equal_mask (equal_mask),
    .equal_sum  (equal_sum)
  );

  // A decision needs a head on every unfinished lane and a free output slot.
  assign fire          = (&(done | head_valid)) && min_valid && (!out_valid || out_ready);
  assign lowest_onehot = {{(R-1){1'b0}}, 1'b1} << min_index;
  assign final_fire    = fire && (&(done | (consume & head_last)));
  assign multi_hit     = |(equal_mask & (equal_mask - 1'b1));
  assign in_ready      = ~done & (~head_valid | consume);

  // Choose which lanes drain on this fire and the value that goes out.
  always_comb begin
    consume    = '0;
    fire_value = head_value[min_index*V +: V];
    if (COMBINE_EQUAL != 0) begin
      fire_value = equal_sum;
      if (fire) consume = equal_mask;
    end else begin
      if (fire) consume = lowest_onehot;
    end
  end

  // Per-lane head registers and fiber-done flags; done clears as a set on the final fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_valid <= '0;
      head_coord <= '0;
      head_value <= '0;
      head_last  <= '0;
      done       <= '0;
    end else begin
      for (int i = 0; i < R; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          head_valid[i]                   <= 1'b1;
          head_coord[lane_lsb(i, C) +: C] <= in_coord[lane_lsb(i, C) +: C];
          head_value[lane_lsb(i, V) +: V] <= in_value[lane_lsb(i, V) +: V];
          head_last[i]                    <= in_last[i];
        end else if (consume[i]) begin
          head_valid[i] <= 1'b0;
        end
      end
      done <= final_fire ? '0 : (done | (consume & head_last));
    end
  end

  // Registered output stage: load on fire, drop valid once taken, hold while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_coord <= '0;
      out_value <= '0;
      out_last  <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_coord <= min_coord;
      out_value <= fire_value;
      out_last  <= final_fire;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of fires that merged more than one lane.
  always_ff @(posedge clock) begin
    if (reset) begin
      dup_count <= '0;
    end else if (fire && (COMBINE_EQUAL != 0) && multi_hit && (dup_count != '1)) begin
      dup_count <= dup_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_radix_stream_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_radix_stream_merger
// Purpose  : Directed self-checking bench; instance 0 combines equal
//            coordinates, instance 1 emits them separately.
// Revision : 1.0 - initial release
// ============================================================================
module tb_radix_stream_merger;

  typedef struct {
    logic [7:0] c;
    logic [7:0] v;
    logic       l;
  } ent_t;

  typedef struct {
    logic [7:0] c;
    logic [7:0] v;
    logic       l;
    int         cyc;
  } out_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  iv   [2];
  logic [3:0]  ir   [2];
  logic [31:0] ic   [2];
  logic [31:0] ivl  [2];
  logic [3:0]  il   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [7:0]  oc   [2];
  logic [7:0]  ovl  [2];
  logic        olst [2];
  logic [15:0] dup  [2];

  ent_t lq [8][$];
  out_t oq [2][$];
  logic out_rdy = 1'b1;
  int   cyc     = 0;
  int   tests   = 0;
  int   failed  = 0;

  always #5 clock = ~clock;

  radix_stream_merger #(
    .MERGER_RADIX(4), .MERGER_COORD_BITS(8), .MERGER_VALUE_BITS(8),
    .COMBINE_EQUAL(1), .DUP_COUNT_BITS(16)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_coord(ic[0]), .in_value(ivl[0]), .in_last(il[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_coord(oc[0]), .out_value(ovl[0]), .out_last(olst[0]),
    .dup_count(dup[0])
  );

  radix_stream_merger #(
    .MERGER_RADIX(4), .MERGER_COORD_BITS(8), .MERGER_VALUE_BITS(8),
    .COMBINE_EQUAL(0), .DUP_COUNT_BITS(16)
  ) dut_sep (
    .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_coord(ic[1]), .in_value(ivl[1]), .in_last(il[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_coord(oc[1]), .out_value(ovl[1]), .out_last(olst[1]),
    .dup_count(dup[1])
  );

  task automatic push(input int s, input int lane, input int c, input int v, input bit l);
    ent_t e;
    e.c = 8'(c); e.v = 8'(v); e.l = l;
    lq[s*4+lane].push_back(e);
  endtask

  // One clock: present queue heads at negedge, sample handshakes, commit at posedge.
  task automatic step();
    logic [3:0] acc [2];
    logic       fs  [2];
    out_t       rec [2];
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        if (lq[s*4+i].size() > 0) begin
          iv[s][i]        = 1'b1;
          ic[s][i*8 +: 8]  = lq[s*4+i][0].c;
          ivl[s][i*8 +: 8] = lq[s*4+i][0].v;
          il[s][i]        = lq[s*4+i][0].l;
        end else begin
          iv[s][i] = 1'b0;
        end
      end
      ordy[s] = out_rdy;
    end
    #1;
    for (int s = 0; s < 2; s++) begin
      acc[s]     = iv[s] & ir[s];
      fs[s]      = ov[s] & ordy[s];
      rec[s].c   = oc[s];
      rec[s].v   = ovl[s];
      rec[s].l   = olst[s];
      rec[s].cyc = cyc;
    end
    @(posedge clock);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) if (acc[s][i]) void'(lq[s*4+i].pop_front());
      if (fs[s]) oq[s].push_back(rec[s]);
    end
    cyc++;
  endtask

  task automatic run_until(input int s, input int n, input int budget);
    for (int k = 0; k < budget && oq[s].size() < n; k++) step();
  endtask

  task automatic do_reset();
    for (int k = 0; k < 8; k++) lq[k].delete();
    @(negedge clock);
    reset = 1'b1;
    iv[0] = '0; iv[1] = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    oq[0].delete(); oq[1].delete();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ov[0] !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %0d want 0", ov[0]); end
    tests++; if (ir[0] !== 4'b1111) begin failed++; $display("FAIL reset_in_ready: got %b want 1111", ir[0]); end
    tests++; if (dup[0] !== 16'd0) begin failed++; $display("FAIL reset_dup_count: got %0d want 0", dup[0]); end
    tests++; if (oc[0] !== 8'd0 || ovl[0] !== 8'd0 || olst[0] !== 1'b0) begin failed++; $display("FAIL reset_out_fields: got c=%0d v=%0d l=%0d want 0 0 0", oc[0], ovl[0], olst[0]); end
    // Fill heads and the output register mid-fiber, then reset.
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(0, i, i + 1, i + 1, 1'b0);
    repeat (4) step();
    tests++; if (ov[0] !== 1'b1) begin failed++; $display("FAIL midreset_pre_valid: got %0d want 1", ov[0]); end
    for (int k = 0; k < 8; k++) lq[k].delete();
    @(negedge clock);
    reset = 1'b1;
    iv[0] = '0; iv[1] = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    tests++; if (ov[0] !== 1'b0) begin failed++; $display("FAIL midreset_out_valid: got %0d want 0", ov[0]); end
    tests++; if (ir[0] !== 4'b1111) begin failed++; $display("FAIL midreset_heads_empty: in_ready got %b want 1111", ir[0]); end
    out_rdy = 1'b1;
  endtask

  task automatic test_disjoint();
    int ec [6] = '{1, 2, 3, 4, 5, 6};
    int ev [6] = '{10, 20, 30, 40, 50, 60};
    do_reset();
    push(0, 0, 1, 10, 1'b0); push(0, 0, 5, 50, 1'b1);
    push(0, 1, 2, 20, 1'b0); push(0, 1, 6, 60, 1'b1);
    push(0, 2, 3, 30, 1'b1);
    push(0, 3, 4, 40, 1'b1);
    run_until(0, 6, 40);
    repeat (3) step();
    tests++; if (oq[0].size() != 6) begin failed++; $display("FAIL disjoint_count: got %0d want 6", oq[0].size()); end
    for (int k = 0; k < 6 && k < oq[0].size(); k++) begin
      tests++;
      if (oq[0][k].c !== 8'(ec[k]) || oq[0][k].v !== 8'(ev[k]) || oq[0][k].l !== (k == 5)) begin
        failed++;
        $display("FAIL disjoint_out%0d: got c=%0d v=%0d l=%0d want c=%0d v=%0d l=%0d", k, oq[0][k].c, oq[0][k].v, oq[0][k].l, ec[k], ev[k], (k == 5));
      end
      if (k > 0) begin
        tests++;
        if (oq[0][k].cyc != oq[0][k-1].cyc + 1) begin failed++; $display("FAIL disjoint_gap%0d: got cycle %0d want %0d", k, oq[0][k].cyc, oq[0][k-1].cyc + 1); end
      end
    end
    tests++; if (dup[0] !== 16'd0) begin failed++; $display("FAIL disjoint_dup: got %0d want 0", dup[0]); end
  endtask

  task automatic test_combine();
    int ec0 [2] = '{7, 9};
    int ev0 [2] = '{7, 3};
    int ec1 [4] = '{7, 7, 9, 9};
    int ev1 [4] = '{3, 4, 1, 2};
    do_reset();
    for (int s = 0; s < 2; s++) begin
      push(s, 0, 7, 3, 1'b1); push(s, 2, 7, 4, 1'b1);
      push(s, 1, 9, 1, 1'b1); push(s, 3, 9, 2, 1'b1);
    end
    run_until(1, 4, 40);
    repeat (3) step();
    tests++; if (oq[0].size() != 2) begin failed++; $display("FAIL combine_count: got %0d want 2", oq[0].size()); end
    for (int k = 0; k < 2 && k < oq[0].size(); k++) begin
      tests++;
      if (oq[0][k].c !== 8'(ec0[k]) || oq[0][k].v !== 8'(ev0[k]) || oq[0][k].l !== (k == 1)) begin
        failed++;
        $display("FAIL combine_out%0d: got c=%0d v=%0d l=%0d want c=%0d v=%0d l=%0d", k, oq[0][k].c, oq[0][k].v, oq[0][k].l, ec0[k], ev0[k], (k == 1));
      end
    end
    tests++; if (dup[0] !== 16'd2) begin failed++; $display("FAIL combine_dup: got %0d want 2", dup[0]); end
    tests++; if (oq[1].size() != 4) begin failed++; $display("FAIL separate_count: got %0d want 4", oq[1].size()); end
    for (int k = 0; k < 4 && k < oq[1].size(); k++) begin
      tests++;
      if (oq[1][k].c !== 8'(ec1[k]) || oq[1][k].v !== 8'(ev1[k]) || oq[1][k].l !== (k == 3)) begin
        failed++;
        $display("FAIL separate_out%0d: got c=%0d v=%0d l=%0d want c=%0d v=%0d l=%0d", k, oq[1][k].c, oq[1][k].v, oq[1][k].l, ec1[k], ev1[k], (k == 3));
      end
    end
    tests++; if (dup[1] !== 16'd0) begin failed++; $display("FAIL separate_dup: got %0d want 0", dup[1]); end
  endtask

  task automatic test_value_wrap();
    do_reset();
    push(0, 0, 5, 200, 1'b1); push(0, 1, 5, 100, 1'b1);
    push(0, 2, 8, 1, 1'b1);   push(0, 3, 8, 2, 1'b1);
    run_until(0, 2, 40);
    tests++; if (oq[0].size() != 2) begin failed++; $display("FAIL wrap_count: got %0d want 2", oq[0].size()); end
    if (oq[0].size() > 0) begin
      tests++; if (oq[0][0].c !== 8'd5 || oq[0][0].v !== 8'd44) begin failed++; $display("FAIL wrap_value: got c=%0d v=%0d want c=5 v=44", oq[0][0].c, oq[0][0].v); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push(0, 0, 1, 101, 1'b0); push(0, 0, 5, 105, 1'b0); push(0, 0, 9, 109, 1'b1);
    push(0, 1, 2, 102, 1'b0); push(0, 1, 6, 106, 1'b1);
    push(0, 2, 3, 103, 1'b0); push(0, 2, 7, 107, 1'b1);
    push(0, 3, 4, 104, 1'b0); push(0, 3, 8, 108, 1'b1);
    out_rdy = 1'b0;
    repeat (3) step();
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      tests++;
      if (ov[0] !== 1'b1 || oc[0] !== 8'd1 || ovl[0] !== 8'd101 || olst[0] !== 1'b0) begin
        failed++;
        $display("FAIL stall_hold%0d: got v=%0d c=%0d val=%0d l=%0d want 1 1 101 0", k, ov[0], oc[0], ovl[0], olst[0]);
      end
      tests++; if (ir[0] !== 4'b0000) begin failed++; $display("FAIL stall_in_ready%0d: got %b want 0000", k, ir[0]); end
    end
    out_rdy = 1'b1;
    run_until(0, 9, 60);
    repeat (4) step();
    tests++; if (oq[0].size() != 9) begin failed++; $display("FAIL stall_count: got %0d want 9", oq[0].size()); end
    for (int k = 0; k < 9 && k < oq[0].size(); k++) begin
      tests++;
      if (oq[0][k].c !== 8'(k + 1) || oq[0][k].v !== 8'(k + 101) || oq[0][k].l !== (k == 8)) begin
        failed++;
        $display("FAIL stall_out%0d: got c=%0d v=%0d l=%0d want c=%0d v=%0d l=%0d", k, oq[0][k].c, oq[0][k].v, oq[0][k].l, k + 1, k + 101, (k == 8));
      end
    end
  endtask

  task automatic test_missing_head();
    int ec [4] = '{0, 1, 2, 3};
    int ev [4] = '{9, 11, 12, 13};
    do_reset();
    push(0, 0, 1, 11, 1'b1); push(0, 1, 2, 12, 1'b1); push(0, 2, 3, 13, 1'b1);
    repeat (5) step();
    #1;
    tests++; if (oq[0].size() != 0 || ov[0] !== 1'b0) begin failed++; $display("FAIL missing_no_output: got count=%0d valid=%0d want 0 0", oq[0].size(), ov[0]); end
    push(0, 3, 0, 9, 1'b1);
    run_until(0, 4, 40);
    tests++; if (oq[0].size() != 4) begin failed++; $display("FAIL missing_count: got %0d want 4", oq[0].size()); end
    for (int k = 0; k < 4 && k < oq[0].size(); k++) begin
      tests++;
      if (oq[0][k].c !== 8'(ec[k]) || oq[0][k].v !== 8'(ev[k]) || oq[0][k].l !== (k == 3)) begin
        failed++;
        $display("FAIL missing_out%0d: got c=%0d v=%0d l=%0d want c=%0d v=%0d l=%0d", k, oq[0][k].c, oq[0][k].v, oq[0][k].l, ec[k], ev[k], (k == 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    int ec [5] = '{3, 10, 11, 12, 13};
    int ev [5] = '{4, 5, 6, 7, 8};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(0, i, 3, 1, 1'b1);
      push(0, i, 10 + i, 5 + i, 1'b1);
    end
    run_until(0, 5, 40);
    tests++; if (oq[0].size() != 5) begin failed++; $display("FAIL b2b_count: got %0d want 5", oq[0].size()); end
    for (int k = 0; k < 5 && k < oq[0].size(); k++) begin
      tests++;
      if (oq[0][k].c !== 8'(ec[k]) || oq[0][k].v !== 8'(ev[k]) || oq[0][k].l !== (k == 0 || k == 4)) begin
        failed++;
        $display("FAIL b2b_out%0d: got c=%0d v=%0d l=%0d want c=%0d v=%0d l=%0d", k, oq[0][k].c, oq[0][k].v, oq[0][k].l, ec[k], ev[k], (k == 0 || k == 4));
      end
    end
    if (oq[0].size() > 1) begin
      tests++; if (oq[0][1].cyc != oq[0][0].cyc + 1) begin failed++; $display("FAIL b2b_bubble: got cycle %0d want %0d", oq[0][1].cyc, oq[0][0].cyc + 1); end
    end
    tests++; if (dup[0] !== 16'd1) begin failed++; $display("FAIL b2b_dup: got %0d want 1", dup[0]); end
  endtask

  initial begin
    iv[0] = '0; iv[1] = '0; ic[0] = '0; ic[1] = '0;
    ivl[0] = '0; ivl[1] = '0; il[0] = '0; il[1] = '0;
    ordy[0] = 1'b1; ordy[1] = 1'b1;
    test_reset();
    test_disjoint();
    test_combine();
    test_value_wrap();
    test_backpressure();
    test_missing_head();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
